// File: rtl/mem_access_stage.sv
// MEM stage: word load/store over a req/ack data bus, stall request while busy, MEM/WB register.
// Optional MEM_TIMEOUT_EN aborts a bus access after TIMEOUT_CYCLES cycles without dmem_ack.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  stall,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] op2_in,
    input  logic [31:0] pc_in,
    input  logic [4:0]  regwr_ad_in,
    input  logic        memread_in,
    input  logic        memwrite_in,
    input  logic        regwrite_in,
    input  logic [1:0]  mem2reg_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_req,
    output logic        mem_err,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_regwr_ad,
    output logic        wb_regwrite
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_err_q, mem_err_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_regwr_ad_q, wb_regwr_ad_d;
    logic        wb_regwrite_q, wb_regwrite_d;
`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic mem_op;
    logic misaligned;
    logic unused_stall;

    assign mem_op       = memread_in | memwrite_in;
    assign misaligned   = mem_op & (alu_res_in[1:0] != 2'b00);
    assign unused_stall = ^stall[3:0];

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        rdata_d      = rdata_q;
        mem_err_d    = 1'b0;
        stall_req    = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    stall_req    = 1'b1;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = memwrite_in;
                    dmem_addr_d  = alu_res_in;
                    dmem_wdata_d = op2_in;
`ifdef MEM_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                    state_d      = BUSY;
                end else if (misaligned) begin
                    mem_err_d = 1'b1;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (dmem_ack) begin
                    // Stores capture 0 so a stale load value never leaks to write-back.
                    rdata_d    = dmem_we_q ? 32'd0 : dmem_rdata;
                    dmem_req_d = 1'b0;
                    state_d    = DONE;
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d    = 32'd0;
                    dmem_req_d = 1'b0;
                    mem_err_d  = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                if (!stall[4]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_data_d     = wb_data_q;
        wb_regwr_ad_d = wb_regwr_ad_q;
        wb_regwrite_d = wb_regwrite_q;
        if (!stall[4]) begin
            if (stall_req) begin
                wb_data_d     = 32'd0;
                wb_regwr_ad_d = 5'd0;
                wb_regwrite_d = 1'b0;
            end else begin
                wb_regwr_ad_d = regwr_ad_in;
                wb_regwrite_d = regwrite_in;
                case (mem2reg_in)
                    2'b01:   wb_data_d = misaligned ? 32'd0 : rdata_q;
                    2'b10:   wb_data_d = pc_in + 32'd4;
                    default: wb_data_d = alu_res_in;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= 32'd0;
            dmem_wdata_q  <= 32'd0;
            rdata_q       <= 32'd0;
            mem_err_q     <= 1'b0;
            wb_data_q     <= 32'd0;
            wb_regwr_ad_q <= 5'd0;
            wb_regwrite_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            dmem_req_q    <= dmem_req_d;
            dmem_we_q     <= dmem_we_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_wdata_q  <= dmem_wdata_d;
            rdata_q       <= rdata_d;
            mem_err_q     <= mem_err_d;
            wb_data_q     <= wb_data_d;
            wb_regwr_ad_q <= wb_regwr_ad_d;
            wb_regwrite_q <= wb_regwrite_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign mem_err     = mem_err_q;
    assign wb_data     = wb_data_q;
    assign wb_regwr_ad = wb_regwr_ad_q;
    assign wb_regwrite = wb_regwrite_q;

endmodule
